delay_fifo_drain: RTL and testbench

Small synchronous FIFO sitting directly downstream of the fixed-latency `delay_3` pipeline. `delay_3` cannot stall, so this block absorbs its output stream and presents it to a consumer through a valid/ready handshake. When the consumer back-pressures for too long, the block drops words and records the loss. It is the standard adapter between free-running delay pipelines and stallable consumers.

---
 rtl/delay_fifo_drain_pkg.sv | 23 ++
 rtl/delay_fifo_drain_sat_counter.sv | 39 +++
 rtl/delay_fifo_drain.sv | 109 ++++++++++
 tb/tb_delay_fifo_drain.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_fifo_drain_pkg.sv
// Shared constants for the delay_fifo_drain adapter: default geometry, derived
// pointer/occupancy widths and the drop-counter saturation value.
package delay_fifo_drain_pkg;

  localparam int FIFO_WIDTH_DEFAULT = 8;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int DROP_CNT_W_DEFAULT = 8;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    if (depth <= 1) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

  localparam int FIFO_PTR_W_DEFAULT   = ptr_width(FIFO_DEPTH_DEFAULT);
  localparam int FIFO_COUNT_W_DEFAULT = FIFO_PTR_W_DEFAULT + 1;

  localparam logic [DROP_CNT_W_DEFAULT-1:0] DROP_CNT_SAT_DEFAULT = {DROP_CNT_W_DEFAULT{1'b1}};

endpackage

// File: rtl/delay_fifo_drain_sat_counter.sv
// Saturating up-counter used to tally words lost to back-pressure.
module sat_counter
  import delay_fifo_drain_pkg::*;
#(
  parameter int CNT_W = DROP_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold once all-ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/delay_fifo_drain.sv
// Non-stallable-to-stallable adapter: a small FIFO that absorbs a free-running
// stream, hands it out over valid/ready, and drops (and counts) words when full.
module delay_fifo_drain
  import delay_fifo_drain_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int CNT_W = DROP_CNT_W_DEFAULT
) (
  input  logic                        _i_clk,
  input  logic                        _i_rst,
  input  logic [WIDTH-1:0]            _i_in_data,
  input  logic                        _i_in_valid,
  input  logic                        _i_out_ready,
  output logic [WIDTH-1:0]            __output,
  output logic                        _o_out_valid,
  output logic [ptr_width(DEPTH):0]   _o_count,
  output logic                        _o_overflow,
  output logic [CNT_W-1:0]            _o_drop_count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;

  // Handshake decode and next-state for pointers, occupancy and flags.
  // Reset masks all three events so nothing moves while it is held.
  always_comb begin
    full_s      = (count_q == FULL_LVL);
    pop_s       = out_valid_q & _i_out_ready & ~_i_rst;
    push_s      = _i_in_valid & (~full_s | pop_s) & ~_i_rst;
    drop_s      = _i_in_valid & full_s & ~pop_s & ~_i_rst;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | drop_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    out_valid_d = (count_d != {OCC_W{1'b0}});
  end

  // Control state; valid is registered from the next occupancy so it never
  // depends on the consumer's ready in the same cycle.
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {OCC_W{1'b0}};
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge _i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= _i_in_data;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk   (_i_clk),
    .rst   (_i_rst),
    .inc   (drop_s),
    .value (_o_drop_count)
  );

  assign __output     = mem_q[rd_ptr_q];
  assign _o_out_valid = out_valid_q;
  assign _o_count     = count_q;
  assign _o_overflow  = overflow_q;

endmodule

// File: tb/tb_delay_fifo_drain.sv
// Directed bench for delay_fifo_drain: a default instance fed optionally through
// a 3-stage delay model, plus a CNT_W=2 instance for drop-counter saturation.
module tb_delay_fifo_drain;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance stimulus and delay_3 model.
  logic       rst         = 1'b1;
  logic [7:0] drv_data    = 8'h00;
  logic       drv_valid   = 1'b0;
  logic       ready       = 1'b0;
  logic       use_chain   = 1'b0;
  logic [7:0] chain_data  = 8'h00;
  logic       chain_valid = 1'b0;
  logic [7:0] d3_d0 = 8'h00, d3_d1 = 8'h00, d3_d2 = 8'h00;
  logic       d3_v0 = 1'b0,  d3_v1 = 1'b0,  d3_v2 = 1'b0;
  logic [7:0] in_data;
  logic       in_valid;

  always_ff @(posedge clk) begin
    d3_d0 <= chain_data;  d3_v0 <= chain_valid;
    d3_d1 <= d3_d0;       d3_v1 <= d3_v0;
    d3_d2 <= d3_d1;       d3_v2 <= d3_v1;
  end

  assign in_data  = use_chain ? d3_d2 : drv_data;
  assign in_valid = use_chain ? d3_v2 : drv_valid;

  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_count;

  delay_fifo_drain dut (
    ._i_clk        (clk),
    ._i_rst        (rst),
    ._i_in_data    (in_data),
    ._i_in_valid   (in_valid),
    ._i_out_ready  (ready),
    .__output      (out_data),
    ._o_out_valid  (out_valid),
    ._o_count      (count),
    ._o_overflow   (overflow),
    ._o_drop_count (drop_count)
  );

  // Narrow-counter instance.
  logic       rst2    = 1'b1;
  logic [7:0] data2   = 8'h00;
  logic       valid2  = 1'b0;
  logic       ready2  = 1'b0;
  logic [7:0] out2;
  logic       out_valid2;
  logic [2:0] count2;
  logic       overflow2;
  logic [1:0] drop2;

  delay_fifo_drain #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) dut2 (
    ._i_clk        (clk),
    ._i_rst        (rst2),
    ._i_in_data    (data2),
    ._i_in_valid   (valid2),
    ._i_out_ready  (ready2),
    .__output      (out2),
    ._o_out_valid  (out_valid2),
    ._o_count      (count2),
    ._o_overflow   (overflow2),
    ._o_drop_count (drop2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two edges with push requested.
    rst = 1'b1; drv_valid = 1'b1; drv_data = 8'h55; ready = 1'b1;
    tick(); tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    drv_valid = 1'b0; rst = 1'b0;
    tick();
    check_eq("idle_count", 32'(count), 32'd0);
    check_eq("idle_valid", 32'(out_valid), 32'd0);

    // Single word through the delay chain.
    use_chain = 1'b1; ready = 1'b1;
    chain_data = 8'h01; chain_valid = 1'b1;
    tick();
    chain_data = 8'h00;
    tick();
    chain_valid = 1'b0;
    tick();
    check_eq("chain_not_yet", 32'(out_valid), 32'd0);
    tick();
    check_eq("chain_w1_valid", 32'(out_valid), 32'd1);
    check_eq("chain_w1_data", 32'(out_data), 32'h01);
    tick();
    check_eq("chain_w0_valid", 32'(out_valid), 32'd1);
    check_eq("chain_w0_data", 32'(out_data), 32'h00);
    tick();
    check_eq("chain_empty", 32'(out_valid), 32'd0);
    use_chain = 1'b0;

    // Fill with ready low.
    ready = 1'b0; drv_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv_data = 8'h10 + 8'(i);
      tick();
    end
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_head", 32'(out_data), 32'h10);

    // Two drops while full.
    drv_data = 8'hAA; tick();
    drv_data = 8'hBB; tick();
    check_eq("ovf_count", 32'(count), 32'd4);
    check_eq("ovf_drop", 32'(drop_count), 32'd2);
    check_eq("ovf_flag", 32'(overflow), 32'd1);

    // Drain in order, dropped words absent.
    drv_valid = 1'b0; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", 32'(out_valid), 32'd1);
      check_eq("drain_data", 32'(out_data), 32'h10 + 32'(i));
      tick();
    end
    check_eq("drain_done", 32'(out_valid), 32'd0);
    check_eq("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous push and pop.
    ready = 1'b0; drv_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv_data = 8'h30 + 8'(i);
      tick();
    end
    drv_data = 8'h20; ready = 1'b1;
    tick();
    check_eq("pp_count", 32'(count), 32'd4);
    check_eq("pp_drop", 32'(drop_count), 32'd2);
    check_eq("pp_head", 32'(out_data), 32'h31);
    drv_valid = 1'b0;
    begin
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'h31; exp_seq[1] = 8'h32; exp_seq[2] = 8'h33; exp_seq[3] = 8'h20;
      for (int i = 0; i < 4; i++) begin
        check_eq("pp_drain", 32'(out_data), 32'(exp_seq[i]));
        tick();
      end
    end
    check_eq("pp_empty", 32'(out_valid), 32'd0);

    // Empty with ready high: nothing happens.
    tick();
    check_eq("empty_ready_count", 32'(count), 32'd0);
    check_eq("empty_ready_valid", 32'(out_valid), 32'd0);

    // Reset mid-operation.
    ready = 1'b0; drv_valid = 1'b1;
    drv_data = 8'h41; tick();
    drv_data = 8'h42; tick();
    check_eq("mid_count", 32'(count), 32'd2);
    rst = 1'b1; tick();
    rst = 1'b0; drv_valid = 1'b0;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
    check_eq("mid_rst_drop", 32'(drop_count), 32'd0);
    tick();
    check_eq("mid_after_count", 32'(count), 32'd0);

    // Saturating drop counter with CNT_W = 2.
    tick();
    rst2 = 1'b0; valid2 = 1'b1; ready2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data2 = 8'h60 + 8'(i);
      tick();
    end
    check_eq("sat_drop0", 32'(drop2), 32'd0);
    for (int i = 0; i < 5; i++) begin
      data2 = 8'hE0 + 8'(i);
      tick();
      if (i == 1) check_eq("sat_drop2", 32'(drop2), 32'd2);
      if (i == 2) check_eq("sat_drop3", 32'(drop2), 32'd3);
    end
    check_eq("sat_hold", 32'(drop2), 32'd3);
    check_eq("sat_ovf", 32'(overflow2), 32'd1);
    check_eq("sat_count", 32'(count2), 32'd4);
    check_eq("sat_head", 32'(out2), 32'h60);
    rst2 = 1'b1; valid2 = 1'b0; tick();
    rst2 = 1'b0;
    check_eq("sat_rst_drop", 32'(drop2), 32'd0);
    check_eq("sat_rst_ovf", 32'(overflow2), 32'd0);
    check_eq("sat_rst_valid", 32'(out_valid2), 32'd0);
    check_eq("sat_rst_count", 32'(count2), 32'd0);
    valid2 = 1'b1; data2 = 8'h77; tick();
    valid2 = 1'b0;
    check_eq("sat_refill_data", 32'(out2), 32'h77);
    check_eq("sat_refill_count", 32'(count2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
